fir_root_ctrl: RTL and testbench

Sequencer that feeds samples into the FIR filter, forwards each filtered result to the iterative ROOT unit, and returns the (FIRout, ROOTout) pair through a valid/ready output port. It also owns the seven 8-bit FIR coefficients (B0..B6) as a double-buffered bank: host writes go to a shadow bank, and the active bank changes only between samples. It sits between the sample source and the FIR/ROOT datapath, replacing direct wiring of Data_i and B0..B6.

---
 rtl/fir_root_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_fir_root_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_root_ctrl.sv
// Sequencer between the sample source and the FIR/ROOT datapath: one sample in flight,
// (FIRout, ROOTout) returned on a valid/ready port, double-buffered FIR coefficient bank.
module fir_root_ctrl #(
   parameter int unsigned FIR_LAT      = 2,
   parameter int unsigned ROOT_TIMEOUT = 64
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       In_valid,
   output logic       In_ready,
   input  logic [7:0] In_data,
   input  logic       Cfg_we,
   input  logic [2:0] Cfg_addr,
   input  logic [7:0] Cfg_data,
   input  logic       Cfg_commit,
   output logic       Cfg_pending,
   output logic [7:0] B0,
   output logic [7:0] B1,
   output logic [7:0] B2,
   output logic [7:0] B3,
   output logic [7:0] B4,
   output logic [7:0] B5,
   output logic [7:0] B6,
   output logic       Fir_en,
   output logic [7:0] Fir_x,
   input  logic [7:0] Fir_y,
   output logic       Root_start,
   output logic [7:0] Root_x,
   input  logic       Root_done,
   input  logic [7:0] Root_c,
   output logic       Out_valid,
   input  logic       Out_ready,
   output logic [7:0] FIRout,
   output logic [7:0] ROOTout,
   output logic       Err_timeout
);

   localparam int unsigned DW    = 8;
   localparam int unsigned NCOEF = 7;
   localparam int unsigned CW    = 4;
   localparam int unsigned TW    = 8;

   typedef enum logic [1:0] {IDLE, FIR_WAIT, ROOT_RUN, OUT_HOLD} state_e;

   state_e                     state_q, state_d;
   logic                       in_ready_q, in_ready_d;
   logic                       pending_q, pending_d;
   logic [NCOEF-1:0][DW-1:0]   active_q, active_d;
   logic [NCOEF-1:0][DW-1:0]   shadow_q, shadow_d;
   logic                       fir_en_q, fir_en_d;
   logic [DW-1:0]              fir_x_q, fir_x_d;
   logic                       root_start_q, root_start_d;
   logic [DW-1:0]              root_x_q, root_x_d;
   logic [DW-1:0]              fir_out_q, fir_out_d;
   logic [DW-1:0]              root_out_q, root_out_d;
   logic                       out_valid_q, out_valid_d;
   logic                       err_q, err_d;
   logic [CW-1:0]              lat_q, lat_d;
   logic [TW-1:0]              tmo_q, tmo_d;

   logic accept_c, swap_c, fir_hit_c, done_c, tmo_c, release_c;

   assign accept_c  = (state_q == IDLE) && in_ready_q && In_valid;
   assign swap_c    = (state_q == IDLE) && pending_q;
   assign fir_hit_c = (state_q == FIR_WAIT) && (lat_q <= CW'(1));
   // Root_done is ignored while Root_start is still high; a late done wins over the timeout.
   assign done_c    = (state_q == ROOT_RUN) && !root_start_q && Root_done;
   assign tmo_c     = (state_q == ROOT_RUN) && !root_start_q && !Root_done &&
                      (tmo_q >= TW'(ROOT_TIMEOUT));
   assign release_c = (state_q == OUT_HOLD) && Out_ready;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q      <= IDLE;
         in_ready_q   <= 1'b0;
         pending_q    <= 1'b0;
         active_q     <= '0;
         shadow_q     <= '0;
         fir_en_q     <= 1'b0;
         fir_x_q      <= '0;
         root_start_q <= 1'b0;
         root_x_q     <= '0;
         fir_out_q    <= '0;
         root_out_q   <= '0;
         out_valid_q  <= 1'b0;
         err_q        <= 1'b0;
         lat_q        <= '0;
         tmo_q        <= '0;
      end else begin
         state_q      <= state_d;
         in_ready_q   <= in_ready_d;
         pending_q    <= pending_d;
         active_q     <= active_d;
         shadow_q     <= shadow_d;
         fir_en_q     <= fir_en_d;
         fir_x_q      <= fir_x_d;
         root_start_q <= root_start_d;
         root_x_q     <= root_x_d;
         fir_out_q    <= fir_out_d;
         root_out_q   <= root_out_d;
         out_valid_q  <= out_valid_d;
         err_q        <= err_d;
         lat_q        <= lat_d;
         tmo_q        <= tmo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:     if (accept_c)             state_d = FIR_WAIT;
         FIR_WAIT: if (fir_hit_c)            state_d = ROOT_RUN;
         ROOT_RUN: if (done_c || tmo_c)      state_d = OUT_HOLD;
         OUT_HOLD: if (release_c)            state_d = IDLE;
      endcase
   end

   always_comb begin
      active_d     = active_q;
      shadow_d     = shadow_q;
      fir_en_d     = 1'b0;
      fir_x_d      = fir_x_q;
      root_start_d = 1'b0;
      root_x_d     = root_x_q;
      fir_out_d    = fir_out_q;
      root_out_d   = root_out_q;
      out_valid_d  = out_valid_q;
      err_d        = err_q;
      lat_d        = lat_q;
      tmo_d        = tmo_q;

      // Address 7 matches no entry and is dropped.
      for (int unsigned i = 0; i < NCOEF; i++) begin
         if (Cfg_we && (Cfg_addr == 3'(i))) shadow_d[i] = Cfg_data;
      end
      // Swap copies the pre-write shadow; a commit in the swap cycle re-arms for the next swap.
      if (swap_c) active_d = shadow_q;
      pending_d = Cfg_commit || (pending_q && !swap_c);

      if (accept_c) begin
         fir_x_d  = In_data;
         fir_en_d = 1'b1;
         lat_d    = CW'(FIR_LAT);
      end

      if (state_q == FIR_WAIT) begin
         if (fir_hit_c) begin
            fir_out_d    = Fir_y;
            root_x_d     = Fir_y;
            root_start_d = 1'b1;
            tmo_d        = '0;
         end else if (lat_q != '0) begin
            lat_d = lat_q - CW'(1);
         end
      end

      if ((state_q == ROOT_RUN) && (tmo_q != '1)) tmo_d = tmo_q + TW'(1);
      if (done_c) begin
         root_out_d  = Root_c;
         out_valid_d = 1'b1;
      end
      if (tmo_c) begin
         root_out_d  = 8'hFF;
         err_d       = 1'b1;
         out_valid_d = 1'b1;
      end
      if (release_c) out_valid_d = 1'b0;

      in_ready_d = (state_d == IDLE) && !pending_d;
   end

   assign In_ready    = in_ready_q;
   assign Cfg_pending = pending_q;
   assign B0          = active_q[0];
   assign B1          = active_q[1];
   assign B2          = active_q[2];
   assign B3          = active_q[3];
   assign B4          = active_q[4];
   assign B5          = active_q[5];
   assign B6          = active_q[6];
   assign Fir_en      = fir_en_q;
   assign Fir_x       = fir_x_q;
   assign Root_start  = root_start_q;
   assign Root_x      = root_x_q;
   assign Out_valid   = out_valid_q;
   assign FIRout      = fir_out_q;
   assign ROOTout     = root_out_q;
   assign Err_timeout = err_q;

endmodule

// File: tb/tb_fir_root_ctrl.sv
// Bench for fir_root_ctrl: directed samples, expected outputs queued at issue and
// checked by an independent output monitor.
module tb_fir_root_ctrl;

   localparam int unsigned FIR_LAT      = 2;
   localparam int unsigned ROOT_TIMEOUT = 64;

   logic       Clk, Rst;
   logic       In_valid, In_ready;
   logic [7:0] In_data;
   logic       Cfg_we, Cfg_commit, Cfg_pending;
   logic [2:0] Cfg_addr;
   logic [7:0] Cfg_data;
   logic [7:0] B0, B1, B2, B3, B4, B5, B6;
   logic       Fir_en, Root_start, Root_done;
   logic [7:0] Fir_x, Fir_y, Root_x, Root_c;
   logic       Out_valid, Out_ready, Err_timeout;
   logic [7:0] FIRout, ROOTout;

   typedef struct packed {
      logic [7:0] fir;
      logic [7:0] root;
      logic       err;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   fir_root_ctrl #(.FIR_LAT(FIR_LAT), .ROOT_TIMEOUT(ROOT_TIMEOUT)) dut (
      .Clk(Clk), .Rst(Rst),
      .In_valid(In_valid), .In_ready(In_ready), .In_data(In_data),
      .Cfg_we(Cfg_we), .Cfg_addr(Cfg_addr), .Cfg_data(Cfg_data),
      .Cfg_commit(Cfg_commit), .Cfg_pending(Cfg_pending),
      .B0(B0), .B1(B1), .B2(B2), .B3(B3), .B4(B4), .B5(B5), .B6(B6),
      .Fir_en(Fir_en), .Fir_x(Fir_x), .Fir_y(Fir_y),
      .Root_start(Root_start), .Root_x(Root_x), .Root_done(Root_done), .Root_c(Root_c),
      .Out_valid(Out_valid), .Out_ready(Out_ready),
      .FIRout(FIRout), .ROOTout(ROOTout), .Err_timeout(Err_timeout)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   function automatic logic [55:0] bank();
      return {B6, B5, B4, B3, B2, B1, B0};
   endfunction

   // Monitor: every completed output handshake must match the oldest queued expectation.
   always @(negedge Clk) begin
      if (!Rst && Out_valid && Out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_out", {FIRout, ROOTout}, 16'hxxxx);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("out_fir", FIRout, e.fir);
            chk("out_root", ROOTout, e.root);
            chk("out_err", Err_timeout, e.err);
         end
      end
   end

   // Issue a sample, check Fir_en / Root_start timing; returns in the Root_start cycle.
   task automatic start_sample(input logic [7:0] din, input logic [7:0] fy,
                               input bit push, input exp_t e);
      int n = 0;
      while (!In_ready && n < 20) begin
         tick();
         n++;
      end
      chk("in_ready_wait", In_ready, 1'b1);
      if (push) sb.push_back(e);
      In_valid = 1'b1;
      In_data  = din;
      Fir_y    = fy;
      tick();
      In_valid = 1'b0;
      chk("fir_en", {Fir_en, Fir_x}, {1'b1, din});
      for (int i = 1; i <= int'(FIR_LAT); i++) begin
         tick();
         if (i < int'(FIR_LAT)) chk("fir_gap", {Fir_en, Root_start}, 2'b00);
      end
      chk("root_start", {Root_start, Root_x, Fir_en}, {1'b1, fy, 1'b0});
   endtask

   // Root_done sampled k edges after the Root_start cycle; glitch also pulses it in that cycle.
   task automatic finish_done(input int k, input logic [7:0] rc, input bit glitch);
      if (glitch) begin
         Root_done = 1'b1;
         Root_c    = 8'hEE;
      end
      for (int i = 0; i < k; i++) begin
         tick();
         Root_done  = 1'b0;
         Cfg_we     = 1'b0;
         Cfg_commit = 1'b0;
      end
      Root_done = 1'b1;
      Root_c    = rc;
      chk("ov_early", Out_valid, 1'b0);
      tick();
      Root_done = 1'b0;
      chk("ov_lat", Out_valid, 1'b1);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   initial begin
      int n;
      Rst = 1'b1; In_valid = 1'b0; In_data = '0;
      Cfg_we = 1'b0; Cfg_addr = '0; Cfg_data = '0; Cfg_commit = 1'b0;
      Fir_y = '0; Root_done = 1'b0; Root_c = '0; Out_ready = 1'b1;
      tick();
      tick();
      chk("rst_outputs", {In_ready, Out_valid, Fir_en, Root_start, Cfg_pending, Err_timeout},
          6'b0);
      chk("rst_data", {FIRout, ROOTout, Fir_x, Root_x}, 32'h0);
      chk("rst_bank", bank(), 56'h0);
      Rst = 1'b0;
      chk("rdy_in_last_rst", In_ready, 1'b0);
      tick();
      chk("rdy_rise", In_ready, 1'b1);

      // Write and commit in the same cycle: the written value joins the swap.
      Cfg_we = 1'b1; Cfg_addr = 3'd0; Cfg_data = 8'h11; Cfg_commit = 1'b1;
      tick();
      Cfg_we = 1'b0; Cfg_commit = 1'b0;
      chk("swap_pending", {Cfg_pending, In_ready, B0}, {1'b1, 1'b0, 8'h00});
      tick();
      chk("swap_b0", {Cfg_pending, In_ready, bank()}, {1'b0, 1'b1, 56'h00000000000011});

      Cfg_we = 1'b1; Cfg_addr = 3'd7; Cfg_data = 8'hAA; Cfg_commit = 1'b1;
      tick();
      Cfg_we = 1'b0; Cfg_commit = 1'b0;
      tick();
      chk("addr7_ignored", bank(), 56'h00000000000011);

      // Shadow write during the swap cycle is not part of that swap.
      Cfg_we = 1'b1; Cfg_addr = 3'd1; Cfg_data = 8'h22; Cfg_commit = 1'b1;
      tick();
      Cfg_commit = 1'b0; Cfg_addr = 3'd2; Cfg_data = 8'h33;
      tick();
      Cfg_we = 1'b0;
      chk("wr_during_swap", bank(), 56'h00000000002211);
      Cfg_commit = 1'b1;
      tick();
      Cfg_commit = 1'b0;
      tick();
      chk("shadow_kept", bank(), 56'h00000000332211);

      // Basic flow.
      start_sample(8'h10, 8'h40, 1'b1, '{fir: 8'h40, root: 8'h08, err: 1'b0});
      finish_done(2, 8'h08, 1'b0);
      tick();
      chk("ov_drop", Out_valid, 1'b0);

      // Root_done during the Root_start cycle must be ignored.
      start_sample(8'h21, 8'h55, 1'b1, '{fir: 8'h55, root: 8'h9A, err: 1'b0});
      finish_done(3, 8'h9A, 1'b1);
      tick();

      // Backpressure.
      start_sample(8'h30, 8'h66, 1'b1, '{fir: 8'h66, root: 8'h77, err: 1'b0});
      Out_ready = 1'b0;
      finish_done(1, 8'h77, 1'b0);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("bp_hold", {Out_valid, In_ready, FIRout, ROOTout}, {1'b1, 1'b0, 8'h66, 8'h77});
      end
      Out_ready = 1'b1;
      tick();
      chk("bp_release", Out_valid, 1'b0);

      // Coefficient write + commit while in ROOT_RUN.
      start_sample(8'h44, 8'h12, 1'b1, '{fir: 8'h12, root: 8'h34, err: 1'b0});
      Cfg_we = 1'b1; Cfg_addr = 3'd3; Cfg_data = 8'h7F; Cfg_commit = 1'b1;
      finish_done(4, 8'h34, 1'b0);
      chk("b3_hold", {Cfg_pending, B3}, {1'b1, 8'h00});
      tick();
      chk("b3_swap_cycle", {In_ready, B3}, {1'b0, 8'h00});
      tick();
      chk("b3_swapped", {In_ready, Cfg_pending, bank()}, {1'b1, 1'b0, 56'h0000007F332211});

      // Timeout: Root_done never comes; outcome equals a done seen ROOT_TIMEOUT edges later.
      start_sample(8'h55, 8'h5A, 1'b1, '{fir: 8'h5A, root: 8'hFF, err: 1'b1});
      chk("err_before", Err_timeout, 1'b0);
      n = 0;
      while (!Out_valid && n < 300) begin
         tick();
         n++;
         if (n == int'(ROOT_TIMEOUT)) chk("err_not_yet", Err_timeout, 1'b0);
      end
      chk("tmo_lat", n, ROOT_TIMEOUT + 1);
      chk("err_set", {Err_timeout, ROOTout}, {1'b1, 8'hFF});
      tick();

      // Err_timeout is sticky across a good sample.
      start_sample(8'h66, 8'h6B, 1'b1, '{fir: 8'h6B, root: 8'h21, err: 1'b1});
      finish_done(1, 8'h21, 1'b0);
      tick();
      chk("err_sticky", Err_timeout, 1'b1);

      // Reset while waiting for ROOT: aborted sample produces nothing.
      Cfg_we = 1'b1; Cfg_addr = 3'd5; Cfg_data = 8'h5C;
      start_sample(8'h77, 8'h7C, 1'b0, '{fir: 8'h00, root: 8'h00, err: 1'b0});
      Cfg_we = 1'b0;
      tick();
      tick();
      Rst = 1'b1;
      Root_done = 1'b1; Root_c = 8'h99;
      tick();
      Rst = 1'b0;
      chk("mid_rst_outputs",
          {In_ready, Out_valid, Fir_en, Root_start, Cfg_pending, Err_timeout}, 6'b0);
      chk("mid_rst_data", {FIRout, ROOTout, Fir_x, Root_x}, 32'h0);
      chk("mid_rst_bank", bank(), 56'h0);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("post_rst_quiet", {Fir_en, Root_start, Out_valid}, 3'b000);
      end
      Root_done = 1'b0;
      Cfg_commit = 1'b1;
      tick();
      Cfg_commit = 1'b0;
      tick();
      chk("shadow_rst", bank(), 56'h0);

      start_sample(8'h88, 8'h8D, 1'b1, '{fir: 8'h8D, root: 8'h42, err: 1'b0});
      finish_done(2, 8'h42, 1'b0);
      tick();
      tick();
      chk("sb_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
